input_debounce: RTL

- Input conditioning stage between the IB input buffers and the LUT/FF logic stage.
- Per bit: synchronises each raw pad input to clk, then filters it so that only levels held stable for STABLE_CYCLES clocks reach the output.
- Emits one-cycle rise/fall pulses for each accepted transition, so the downstream LUT/DFF stage sees clean, glitch-free signals.

---
 rtl/input_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - per-bit synchroniser, stability filter and edge pulses (optional INPUT_DEBOUNCE_SYNC_EN: two-flop sync)
module input_debounce #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    // Terminal count: the last mismatching sample before the level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchronised view of din that the filter compares against dout.
    logic [WIDTH-1:0] sync_q;

`ifdef INPUT_DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] meta_q;

    // Two-flop chain: the first stage may go metastable, only the second is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end
`else
    // Single capture flop; adequate when din is already synchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= din;
        end
    end
`endif

    // Per-bit stability counters and registered outputs.
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            dout_q;
    logic [WIDTH-1:0]            dout_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic                        busy_q;
    logic                        busy_d;

    // Next-state filter: any matching sample clears progress, a full run of
    // mismatches commits the new level and fires exactly one pulse.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        busy_d = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (sync_q[k] == dout_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                dout_d[k] = sync_q[k];
                cnt_d[k]  = '0;
                rise_d[k] = sync_q[k];
                fall_d[k] = ~sync_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
            if (cnt_d[k] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    // State update; reset drops all progress and forces outputs low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule
